mgmt_gpio_blink_gen: RTL and testbench
======================================

// Module: mgmt_gpio_blink_gen
// PURPOSE
//  Hardware pattern generator for the management GPIO pad. It drives a programmed
//  number of blinks (high-then-low pulses) with a programmable half-period.
//  Management-core CSR logic starts it; pad and pad-control logic consume the outputs.
//  It is the driving end of the blink protocol: a bench monitor counts falling edges
//  on the gpio pin.
// PARAMETERS
//  CNT_W  24  width of half-period cycle counter
//  NUM_W  8   width of blink count
// PORTS
//  sys_clk      in   1      single clock; all logic on rising edge
//  sys_rst      in   1      synchronous reset, active-high
//  start        in   1      start request; sampled only in IDLE
//  half_period  in   CNT_W  cycles per high phase and per low phase; latched on start
//  num_blinks   in   NUM_W  blinks to emit; latched on start
//  abort        in   1      terminate the pattern immediately
//  gpio_out     out  1      pad output value
//  gpio_oeb     out  1      pad output enable, active-low
//  busy         out  1      high whenever state != IDLE
//  done         out  1      one-cycle pulse on normal completion
//  blinks_done  out  NUM_W  completed blinks (falling edges) in current/last run
//  irq          out  1      [MGMT_BLINK_IRQ_EN only] sticky completion interrupt
//  irq_clr      in   1      [MGMT_BLINK_IRQ_EN only] clears irq
// BEHAVIOUR
//  - Reset: state=IDLE; gpio_out=0, gpio_oeb=1, busy=0, done=0, blinks_done=0, irq=0;
//    latched registers cleared. Reset mid-run abandons the pattern with no done pulse.
//  - FSM states: IDLE, HIGH, LOW, DONE. All outputs are registered.
//  - IDLE: start=1 & abort=0 at cycle t:
//    - latch H=half_period (H=0 is treated as 1) and N=num_blinks;
//    - clear blinks_done;
//    - if N=0, go to DONE; otherwise go to HIGH.
//  - HIGH: gpio_out=1 for exactly H cycles, then LOW. blinks_done increments by 1 on
//    the HIGH->LOW transition, so it is visible in the first LOW cycle.
//  - LOW: gpio_out=0 for exactly H cycles. Then go to DONE if blinks_done==N,
//    else back to HIGH.
//  - DONE: lasts one cycle, done=1, gpio_out=0; then IDLE.
//  - Timing, N>0: gpio_out high at cycles t+1..t+H. Blink k rises at t+1+2(k-1)H.
//    done asserted at cycle t+2NH+1.
//  - Timing, N=0: done asserted at cycle t+1; gpio_out never rises.
//  - gpio_oeb=0 in HIGH, LOW and DONE; gpio_oeb=1 in IDLE.
//  - start while busy is ignored. The latched H and N never change mid-run.
//  - abort in any non-IDLE state: next cycle state=IDLE, gpio_out=0, gpio_oeb=1,
//    no done pulse; blinks_done holds its count.
//  - abort and start in the same IDLE cycle: abort wins, no run starts.
//  - blinks_done holds its value after DONE/abort until the next accepted start.
//  - Counter wrap: the half-period counter never wraps (it reloads per phase).
//    With N=2^NUM_W-1 the count reaches all-ones exactly at completion.
// CONFIGURATION
//  - MGMT_BLINK_IRQ_EN defined: irq and irq_clr ports exist.
//    - irq is set in the cycle after done, stays high until the cycle after irq_clr=1.
//    - set and clear in the same cycle: set wins.
//    - abort does not set irq.
//  - MGMT_BLINK_IRQ_EN undefined: irq and irq_clr ports and all irq logic are absent;
//    all other behaviour is identical.
// TESTING
//  1 Reset: hold sys_rst 5 cycles -> gpio_out=0, gpio_oeb=1, busy=0, done=0,
//    blinks_done=0.
//  2 start, N=10, H=4 at cycle t -> 10 falling edges; highs at t+1..t+4,
//    t+9..t+12, ...; done only at t+81; blinks_done=10; busy falls at t+82.
//  3 start, N=0, H=7 -> done at t+1, gpio_out stays 0.
//    Then start, N=2, H=0 -> pattern 1,0,1,0 on t+1..t+4, done at t+5.
//  4 start, N=10, H=4; abort in the first LOW cycle after blink 3 -> next cycle
//    gpio_out=0, gpio_oeb=1, busy=0; no done; blinks_done=3.
//  5 start pulsed every cycle while busy (N=3, H=2) -> exactly one run, done at t+13.
//    start+abort together in IDLE -> busy stays 0.
//  6 [MGMT_BLINK_IRQ_EN] run N=1, H=1 -> done at t+3, irq=1 from t+4.
//    irq_clr coincident with the next done -> irq stays 1.
//    Lone irq_clr -> irq=0 next cycle.

Source files
------------

// File: rtl/mgmt_gpio_blink_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mgmt_gpio_blink_gen                                        |
// | Description : Blink pattern generator for the management GPIO pad.       |
// |               Emits num_blinks high-then-low pulses, each phase lasting  |
// |               half_period cycles, then pulses done for one cycle.        |
// | Options     : MGMT_BLINK_IRQ_EN adds a sticky completion interrupt       |
// |               (irq) with its clear input (irq_clr).                      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module mgmt_gpio_blink_gen #(
   parameter int CNT_W = 24,
   parameter int NUM_W = 8
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   input  logic             start,
   input  logic [CNT_W-1:0] half_period,
   input  logic [NUM_W-1:0] num_blinks,
   input  logic             abort,
`ifdef MGMT_BLINK_IRQ_EN
   input  logic             irq_clr,
   output logic             irq,
`endif
   output logic             gpio_out,
   output logic             gpio_oeb,
   output logic             busy,
   output logic             done,
   output logic [NUM_W-1:0] blinks_done
);

   localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);
   localparam logic [NUM_W-1:0] c_num_one = NUM_W'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_HIGH = 2'd1,
      S_LOW  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_half;
   logic [NUM_W-1:0] r_num;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_h_eff;

   // A zero half-period would give an empty phase, so it behaves as one cycle
   assign w_h_eff = (half_period == '0) ? c_cnt_one : half_period;

   // Pattern FSM; r_cnt holds the remaining cycles of the current phase minus one
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         r_state     <= S_IDLE;
         r_half      <= '0;
         r_num       <= '0;
         r_cnt       <= '0;
         gpio_out    <= 1'b0;
         gpio_oeb    <= 1'b1;
         busy        <= 1'b0;
         done        <= 1'b0;
         blinks_done <= '0;
      end else begin
         done <= 1'b0;
         if (r_state != S_IDLE && abort) begin
            // Abort drops straight back to idle and keeps the blink count
            r_state  <= S_IDLE;
            gpio_out <= 1'b0;
            gpio_oeb <= 1'b1;
            busy     <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (start && !abort) begin
                     r_half      <= w_h_eff;
                     r_num       <= num_blinks;
                     r_cnt       <= w_h_eff - c_cnt_one;
                     blinks_done <= '0;
                     busy        <= 1'b1;
                     gpio_oeb    <= 1'b0;
                     if (num_blinks == '0) begin
                        r_state <= S_DONE;
                        done    <= 1'b1;
                     end else begin
                        r_state  <= S_HIGH;
                        gpio_out <= 1'b1;
                     end
                  end
               end
               S_HIGH: begin
                  if (r_cnt == '0) begin
                     r_state     <= S_LOW;
                     gpio_out    <= 1'b0;
                     r_cnt       <= r_half - c_cnt_one;
                     blinks_done <= blinks_done + c_num_one;
                  end else begin
                     r_cnt <= r_cnt - c_cnt_one;
                  end
               end
               S_LOW: begin
                  if (r_cnt == '0) begin
                     if (blinks_done == r_num) begin
                        r_state <= S_DONE;
                        done    <= 1'b1;
                     end else begin
                        r_state  <= S_HIGH;
                        gpio_out <= 1'b1;
                        r_cnt    <= r_half - c_cnt_one;
                     end
                  end else begin
                     r_cnt <= r_cnt - c_cnt_one;
                  end
               end
               default: begin
                  // S_DONE: single-cycle completion state
                  r_state  <= S_IDLE;
                  gpio_out <= 1'b0;
                  gpio_oeb <= 1'b1;
                  busy     <= 1'b0;
               end
            endcase
         end
      end
   end

`ifdef MGMT_BLINK_IRQ_EN
   // Sticky interrupt: set the cycle after done, set has priority over clear
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         irq <= 1'b0;
      end else if (done) begin
         irq <= 1'b1;
      end else if (irq_clr) begin
         irq <= 1'b0;
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mgmt_gpio_blink_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_mgmt_gpio_blink_gen                                     |
// | Description : Directed self-checking bench for mgmt_gpio_blink_gen.      |
// |               Define MGMT_BLINK_IRQ_EN to include the interrupt checks.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_mgmt_gpio_blink_gen;

   localparam int CNT_W = 24;
   localparam int NUM_W = 8;

   logic             clk;
   logic             rst;
   logic             start;
   logic [CNT_W-1:0] half_period;
   logic [NUM_W-1:0] num_blinks;
   logic             abort;
   logic             gpio_out;
   logic             gpio_oeb;
   logic             busy;
   logic             done;
   logic [NUM_W-1:0] blinks_done;
`ifdef MGMT_BLINK_IRQ_EN
   logic             irq_clr;
   logic             irq;
`endif

   int n_checks;
   int n_fail;

   mgmt_gpio_blink_gen #(.CNT_W(CNT_W), .NUM_W(NUM_W)) dut (
      .sys_clk     (clk),
      .sys_rst     (rst),
      .start       (start),
      .half_period (half_period),
      .num_blinks  (num_blinks),
      .abort       (abort),
`ifdef MGMT_BLINK_IRQ_EN
      .irq_clr     (irq_clr),
      .irq         (irq),
`endif
      .gpio_out    (gpio_out),
      .gpio_oeb    (gpio_oeb),
      .busy        (busy),
      .done        (done),
      .blinks_done (blinks_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to 1 time unit after the next rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Start a run and check every cycle against the closed-form timing
   task automatic run_pattern(input int n, input int h);
      int hh;
      int last;
      int falls;
      logic prev;
      logic exp_hi;
      hh    = (h == 0) ? 1 : h;
      last  = 2 * n * hh + 1;
      falls = 0;
      prev  = 1'b0;
      half_period = CNT_W'(h);
      num_blinks  = NUM_W'(n);
      start = 1'b1;
      step();
      start = 1'b0;
      for (int c = 1; c <= last + 1; c++) begin
         exp_hi = (c <= 2 * n * hh) && (((c - 1) % (2 * hh)) < hh);
         check($sformatf("gpio_out n%0d h%0d c%0d", n, h, c), 32'(gpio_out), 32'(exp_hi));
         check($sformatf("done n%0d h%0d c%0d", n, h, c), 32'(done), 32'(c == last));
         check($sformatf("busy n%0d h%0d c%0d", n, h, c), 32'(busy), 32'(c <= last));
         check($sformatf("oeb n%0d h%0d c%0d", n, h, c), 32'(gpio_oeb), 32'(c > last));
         if (prev && !gpio_out) falls++;
         prev = gpio_out;
         if (c == last)
            check($sformatf("blinks_done n%0d h%0d", n, h), 32'(blinks_done), 32'(n));
         if (c <= last) step();
      end
      check($sformatf("falling_edges n%0d h%0d", n, h), 32'(falls), 32'(n));
   endtask

   initial begin
      int done_seen;
      n_checks    = 0;
      n_fail      = 0;
      rst         = 1'b1;
      start       = 1'b0;
      abort       = 1'b0;
      half_period = '0;
      num_blinks  = '0;
`ifdef MGMT_BLINK_IRQ_EN
      irq_clr     = 1'b0;
`endif

      // Reset
      repeat (5) step();
      rst = 1'b0;
      check("rst gpio_out", 32'(gpio_out), 32'd0);
      check("rst gpio_oeb", 32'(gpio_oeb), 32'd1);
      check("rst busy", 32'(busy), 32'd0);
      check("rst done", 32'(done), 32'd0);
      check("rst blinks_done", 32'(blinks_done), 32'd0);
`ifdef MGMT_BLINK_IRQ_EN
      check("rst irq", 32'(irq), 32'd0);
`endif
      step();

      // Normal runs, zero-blink run and zero half-period run
      run_pattern(10, 4);
      step();
      run_pattern(0, 7);
      step();
      run_pattern(2, 0);
      step();
      run_pattern(3, 3);
      step();

      // Abort in the first LOW cycle after blink 3 (cycle t+21)
      half_period = 24'd4;
      num_blinks  = 8'd10;
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (20) step();
      check("abort pre gpio_out", 32'(gpio_out), 32'd0);
      check("abort pre blinks", 32'(blinks_done), 32'd3);
      abort = 1'b1;
      step();
      abort = 1'b0;
      check("abort gpio_out", 32'(gpio_out), 32'd0);
      check("abort gpio_oeb", 32'(gpio_oeb), 32'd1);
      check("abort busy", 32'(busy), 32'd0);
      check("abort done", 32'(done), 32'd0);
      check("abort blinks", 32'(blinks_done), 32'd3);
      done_seen = 0;
      for (int i = 0; i < 10; i++) begin
         if (done) done_seen++;
         step();
      end
      check("abort no done", 32'(done_seen), 32'd0);
      check("abort blinks hold", 32'(blinks_done), 32'd3);

      // start held every cycle while busy; inputs changed mid-run
      half_period = 24'd2;
      num_blinks  = 8'd3;
      start = 1'b1;
      step();
      half_period = 24'd9;
      num_blinks  = 8'd1;
      for (int c = 1; c <= 13; c++) begin
         check($sformatf("hold done c%0d", c), 32'(done), 32'(c == 13));
         check($sformatf("hold busy c%0d", c), 32'(busy), 32'd1);
         if (c == 13) start = 1'b0;
         step();
      end
      check("hold busy after", 32'(busy), 32'd0);
      check("hold blinks", 32'(blinks_done), 32'd3);
      step();
      check("hold no restart", 32'(busy), 32'd0);

      // start and abort together in IDLE
      start = 1'b1;
      abort = 1'b1;
      step();
      start = 1'b0;
      abort = 1'b0;
      check("start+abort busy", 32'(busy), 32'd0);
      check("start+abort oeb", 32'(gpio_oeb), 32'd1);
      check("start+abort gpio", 32'(gpio_out), 32'd0);
      step();
      check("start+abort busy2", 32'(busy), 32'd0);

      // Full-scale blink count reaches all-ones exactly at completion
      run_pattern(255, 1);
      step();

`ifdef MGMT_BLINK_IRQ_EN
      // irq: clear the leftover flag first
      irq_clr = 1'b1;
      step();
      irq_clr = 1'b0;
      check("irq cleared", 32'(irq), 32'd0);
      half_period = 24'd1;
      num_blinks  = 8'd1;
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      check("irq t2", 32'(irq), 32'd0);
      step();
      check("irq done t3", 32'(done), 32'd1);
      check("irq t3", 32'(irq), 32'd0);
      step();
      check("irq set t4", 32'(irq), 32'd1);
      step();
      check("irq sticky", 32'(irq), 32'd1);
      // Clear coincident with the next done
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      check("irq2 done", 32'(done), 32'd1);
      irq_clr = 1'b1;
      step();
      irq_clr = 1'b0;
      check("irq set wins", 32'(irq), 32'd1);
      step();
      check("irq still set", 32'(irq), 32'd1);
      irq_clr = 1'b1;
      step();
      irq_clr = 1'b0;
      check("irq lone clr", 32'(irq), 32'd0);
      // Abort does not set irq
      start = 1'b1;
      step();
      start = 1'b0;
      abort = 1'b1;
      step();
      abort = 1'b0;
      step();
      step();
      check("irq no abort set", 32'(irq), 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Global time limit so the run always ends
   initial begin
      #2000000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
